// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the SRAM-like bus bridge: channel FSM states
// and the byte-enable to (size, byte offset) encoding.
package sram_like_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_e;

    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HALF  = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [2:0] SIZE_DWORD = 3'd3;

    // Widest byte-enable the helper handles (DATA_W up to 512).
    localparam int MAX_SEL_W = 64;

    typedef struct packed {
        logic [2:0] size;
        logic [5:0] off;
    } size_off_t;

    // Power-of-two enable counts map to a narrow access at the lowest enabled
    // lane; any other pattern becomes an aligned full-width access.
    function automatic size_off_t wen_to_size_off(input logic [MAX_SEL_W-1:0] wen,
                                                  input logic [2:0]           full_size);
        size_off_t r;
        int        pop;
        logic      found;
        r.size = full_size;
        r.off  = '0;
        pop    = 0;
        found  = 1'b0;
        for (int i = 0; i < MAX_SEL_W; i++) begin
            if (wen[i]) begin
                pop = pop + 1;
                if (!found) begin
                    r.off = 6'(i);
                    found = 1'b1;
                end
            end
        end
        if (pop != 0 && (pop & (pop - 1)) == 0) begin
            r.size = 3'd0;
            for (int k = 1; k < 7; k++) begin
                if (pop == (1 << k)) r.size = 3'(k);
            end
        end else begin
            r.off = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_like_channel.sv
// One split-transaction channel: registers the core request, runs the
// IDLE/ADDR/DATA/HOLD handshake and reports whether the core must stall.
module sram_like_channel
    import sram_like_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int SEL_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [SEL_W-1:0]  wen_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              stall_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              req_o,
    output logic              wr_o,
    output logic [2:0]        size_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              addr_ok_i,
    input  logic              data_ok_i,
    input  logic [DATA_W-1:0] rdata_i,
    output state_e            state_o
);

    localparam logic [2:0]        FULL_SIZE = 3'($clog2(SEL_W));
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(SEL_W - 1);

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [2:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    size_off_t         so;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        so      = wen_to_size_off(MAX_SEL_W'(wen_i), FULL_SIZE);
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = ADDR;
                    wdata_d = wdata_i;
                    if (wen_i == '0) begin
                        wr_d   = 1'b0;
                        size_d = FULL_SIZE;
                        addr_d = addr_i;
                    end else begin
                        wr_d   = 1'b1;
                        size_d = so.size;
                        addr_d = (addr_i & ~OFF_MASK) | (ADDR_W'(so.off) & OFF_MASK);
                    end
                end
            end
            ADDR: begin
                // data_ok without addr_ok belongs to no request of ours.
                if (addr_ok_i) begin
                    if (data_ok_i) begin
                        state_d = HOLD;
                        if (!wr_q) rdata_d = rdata_i;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (data_ok_i) begin
                    state_d = HOLD;
                    if (!wr_q) rdata_d = rdata_i;
                end
            end
            HOLD: begin
                if (!stall_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy_o      = (state_q == IDLE && en_i) || state_q == ADDR || state_q == DATA;
    assign req_o       = (state_q == ADDR);
    assign wr_o        = wr_q;
    assign size_o      = size_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign cpu_rdata_o = rdata_q;
    assign state_o     = state_q;

endmodule

// File: rtl/sram_like_bridge.sv
// Bridges the core's single-cycle fetch and load/store ports to an SRAM-like
// bus; the core stalls until both channels have finished this cycle's access.
module sram_like_bridge
    import sram_like_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int SEL_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_inst_en,
    input  logic [ADDR_W-1:0] cpu_inst_addr,
    output logic [DATA_W-1:0] cpu_inst_rdata,
    input  logic              cpu_data_en,
    input  logic [SEL_W-1:0]  cpu_data_wen,
    input  logic [ADDR_W-1:0] cpu_data_addr,
    input  logic [DATA_W-1:0] cpu_data_wdata,
    output logic [DATA_W-1:0] cpu_data_rdata,
    output logic              cpu_stall,
    output logic              inst_req,
    output logic              inst_wr,
    output logic [2:0]        inst_size,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_wdata,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic              data_req,
    output logic              data_wr,
    output logic [2:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output state_e            dbg_inst_state,
    output state_e            dbg_data_state
);

    logic busy_inst, busy_data;

    sram_like_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_inst (
        .clk         (clk),
        .rst         (rst),
        .en_i        (cpu_inst_en),
        .wen_i       ('0),
        .addr_i      (cpu_inst_addr),
        .wdata_i     ('0),
        .stall_i     (cpu_stall),
        .busy_o      (busy_inst),
        .cpu_rdata_o (cpu_inst_rdata),
        .req_o       (inst_req),
        .wr_o        (inst_wr),
        .size_o      (inst_size),
        .addr_o      (inst_addr),
        .wdata_o     (inst_wdata),
        .addr_ok_i   (inst_addr_ok),
        .data_ok_i   (inst_data_ok),
        .rdata_i     (inst_rdata),
        .state_o     (dbg_inst_state)
    );

    sram_like_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data (
        .clk         (clk),
        .rst         (rst),
        .en_i        (cpu_data_en),
        .wen_i       (cpu_data_wen),
        .addr_i      (cpu_data_addr),
        .wdata_i     (cpu_data_wdata),
        .stall_i     (cpu_stall),
        .busy_o      (busy_data),
        .cpu_rdata_o (cpu_data_rdata),
        .req_o       (data_req),
        .wr_o        (data_wr),
        .size_o      (data_size),
        .addr_o      (data_addr),
        .wdata_o     (data_wdata),
        .addr_ok_i   (data_addr_ok),
        .data_ok_i   (data_data_ok),
        .rdata_i     (data_rdata),
        .state_o     (dbg_data_state)
    );

    assign cpu_stall = busy_inst | busy_data;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: table of single-access vectors on the
// data channel plus hand-written fetch, split, concurrent and reset sequences.
module tb_sram_like_bridge;
    import sram_like_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_inst_en;
    logic [31:0] cpu_inst_addr;
    logic [31:0] cpu_inst_rdata;
    logic        cpu_data_en;
    logic [3:0]  cpu_data_wen;
    logic [31:0] cpu_data_addr;
    logic [31:0] cpu_data_wdata;
    logic [31:0] cpu_data_rdata;
    logic        cpu_stall;
    logic        inst_req, inst_wr;
    logic [2:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [2:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    state_e      dbg_inst_state, dbg_data_state;

    int n_checks = 0;
    int n_errors = 0;

    sram_like_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_inst_en    (cpu_inst_en),
        .cpu_inst_addr  (cpu_inst_addr),
        .cpu_inst_rdata (cpu_inst_rdata),
        .cpu_data_en    (cpu_data_en),
        .cpu_data_wen   (cpu_data_wen),
        .cpu_data_addr  (cpu_data_addr),
        .cpu_data_wdata (cpu_data_wdata),
        .cpu_data_rdata (cpu_data_rdata),
        .cpu_stall      (cpu_stall),
        .inst_req       (inst_req),
        .inst_wr        (inst_wr),
        .inst_size      (inst_size),
        .inst_addr      (inst_addr),
        .inst_wdata     (inst_wdata),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .dbg_inst_state (dbg_inst_state),
        .dbg_data_state (dbg_data_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [2:0]  exp_size;
        logic        exp_wr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_inst_en    = 1'b0;
        cpu_inst_addr  = '0;
        cpu_data_en    = 1'b0;
        cpu_data_wen   = '0;
        cpu_data_addr  = '0;
        cpu_data_wdata = '0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = '0;
        data_addr_ok   = 1'b0;
        data_data_ok   = 1'b0;
        data_rdata     = '0;
    endtask

    logic [31:0] exp_data_rdata;
    int          req_cnt, stall_cnt;

    initial begin
        vecs[0] = '{4'b0000, 32'h8000_1004, 32'h0,         32'h1122_3344, 32'h8000_1004, 3'd2, 1'b0};
        vecs[1] = '{4'b0100, 32'h8000_0010, 32'h00AB_0000, 32'hFFFF_FFFF, 32'h8000_0012, 3'd0, 1'b1};
        vecs[2] = '{4'b1100, 32'h8000_0010, 32'hBEEF_0000, 32'hFFFF_FFFF, 32'h8000_0012, 3'd1, 1'b1};
        vecs[3] = '{4'b0111, 32'h8000_0010, 32'h0012_3456, 32'hFFFF_FFFF, 32'h8000_0010, 3'd2, 1'b1};
        vecs[4] = '{4'b1111, 32'h8000_0023, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 32'h8000_0020, 3'd2, 1'b1};
        vecs[5] = '{4'b0001, 32'h8000_0013, 32'h0000_0077, 32'hFFFF_FFFF, 32'h8000_0010, 3'd0, 1'b1};
        vecs[6] = '{4'b0010, 32'h8000_000C, 32'h0000_6600, 32'hFFFF_FFFF, 32'h8000_000D, 3'd0, 1'b1};
        vecs[7] = '{4'b0000, 32'h8000_0003, 32'h0,         32'hCAFE_F00D, 32'h8000_0003, 3'd2, 1'b0};

        // Reset, with a fetch request raised while reset is held.
        rst = 1'b1;
        idle_inputs();
        step();
        cpu_inst_en = 1'b1;
        #1;
        check("reset_stall_follows_en_hi", 64'(cpu_stall), 64'd1);
        step();
        cpu_inst_en = 1'b0;
        #1;
        check("reset_stall_follows_en_lo", 64'(cpu_stall), 64'd0);
        check("reset_inst_req", 64'(inst_req), 64'd0);
        check("reset_data_req", 64'(data_req), 64'd0);
        check("reset_data_bus", {data_addr, 29'(data_wdata), data_size}, 64'd0);
        check("reset_data_wr", 64'(data_wr), 64'd0);
        check("reset_inst_bus", {inst_addr, 29'(inst_wdata), inst_size}, 64'd0);
        check("reset_rdata", {cpu_inst_rdata, cpu_data_rdata}, 64'd0);
        check("reset_state", {60'd0, dbg_inst_state, dbg_data_state}, {60'd0, IDLE, IDLE});
        rst = 1'b0;
        step();

        // Single fetch: ok in cycle 1, stall 1,1,0.
        cpu_inst_en   = 1'b1;
        cpu_inst_addr = 32'hBFC0_0000;
        #1;
        check("fetch_c0_stall", 64'(cpu_stall), 64'd1);
        check("fetch_c0_req", 64'(inst_req), 64'd0);
        step();
        check("fetch_c1_req", 64'(inst_req), 64'd1);
        check("fetch_c1_stall", 64'(cpu_stall), 64'd1);
        check("fetch_c1_addr", 64'(inst_addr), 64'hBFC0_0000);
        check("fetch_c1_size", 64'(inst_size), 64'd2);
        check("fetch_c1_wr", 64'(inst_wr), 64'd0);
        inst_addr_ok = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h3C01_0001;
        step();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        cpu_inst_en  = 1'b0;
        #1;
        check("fetch_c2_req", 64'(inst_req), 64'd0);
        check("fetch_c2_stall", 64'(cpu_stall), 64'd0);
        check("fetch_c2_rdata", 64'(cpu_inst_rdata), 64'h3C01_0001);
        check("fetch_c2_state", 64'(dbg_inst_state), 64'(HOLD));
        step();
        check("fetch_c3_state", 64'(dbg_inst_state), 64'(IDLE));
        check("fetch_c3_rdata_held", 64'(cpu_inst_rdata), 64'h3C01_0001);

        // Table of single-cycle-latency data accesses.
        exp_data_rdata = 32'h0;
        for (int i = 0; i < 8; i++) begin
            cpu_data_en    = 1'b1;
            cpu_data_wen   = vecs[i].wen;
            cpu_data_addr  = vecs[i].addr;
            cpu_data_wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_c0_stall", i), 64'(cpu_stall), 64'd1);
            step();
            check($sformatf("vec%0d_req", i), 64'(data_req), 64'd1);
            check($sformatf("vec%0d_addr", i), 64'(data_addr), 64'(vecs[i].exp_addr));
            check($sformatf("vec%0d_size", i), 64'(data_size), 64'(vecs[i].exp_size));
            check($sformatf("vec%0d_wr", i), 64'(data_wr), 64'(vecs[i].exp_wr));
            check($sformatf("vec%0d_wdata", i), 64'(data_wdata), 64'(vecs[i].wdata));
            data_addr_ok = 1'b1;
            data_data_ok = 1'b1;
            data_rdata   = vecs[i].rdata;
            if (vecs[i].wen == 4'b0000) exp_data_rdata = vecs[i].rdata;
            step();
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = 32'h0;
            cpu_data_en  = 1'b0;
            #1;
            check($sformatf("vec%0d_stall_drop", i), 64'(cpu_stall), 64'd0);
            check($sformatf("vec%0d_req_drop", i), 64'(data_req), 64'd0);
            check($sformatf("vec%0d_rdata", i), 64'(cpu_data_rdata), 64'(exp_data_rdata));
            step();
            check($sformatf("vec%0d_idle", i), 64'(dbg_data_state), 64'(IDLE));
        end

        // Split handshake: addr_ok in cycle 3, data_ok in cycle 5.
        req_cnt   = 0;
        stall_cnt = 0;
        cpu_data_wen   = '0;
        cpu_data_addr  = 32'h8000_1004;
        cpu_data_wdata = '0;
        for (int c = 0; c < 10; c++) begin
            cpu_data_en  = (c < 6);
            data_addr_ok = (c == 3);
            data_data_ok = (c == 5);
            data_rdata   = (c == 5) ? 32'h0BAD_BEEF : 32'h0;
            #1;
            if (data_req) req_cnt++;
            if (cpu_stall) stall_cnt++;
            if (c == 2) check("split_size", 64'(data_size), 64'd2);
            if (c == 4) check("split_state_data", 64'(dbg_data_state), 64'(DATA));
            step();
        end
        check("split_req_cycles", 64'(req_cnt), 64'd3);
        check("split_stall_cycles", 64'(stall_cnt), 64'd6);
        check("split_rdata", 64'(cpu_data_rdata), 64'h0BAD_BEEF);
        idle_inputs();
        #1;

        // Concurrent: fetch completes in cycle 1, load in cycle 4.
        stall_cnt     = 0;
        cpu_inst_addr = 32'hBFC0_0004;
        cpu_data_addr = 32'h8000_0040;
        for (int c = 0; c < 7; c++) begin
            cpu_inst_en  = (c < 5);
            cpu_data_en  = (c < 5);
            inst_addr_ok = (c == 1);
            inst_data_ok = (c == 1);
            inst_rdata   = (c == 1) ? 32'h2402_0005 : 32'h0;
            data_addr_ok = (c == 2);
            data_data_ok = (c == 4);
            data_rdata   = (c == 4) ? 32'h1357_9BDF : 32'h0;
            #1;
            if (cpu_stall) stall_cnt++;
            if (c == 3) check("conc_c3_inst_hold", 64'(dbg_inst_state), 64'(HOLD));
            if (c == 4) check("conc_c4_stall", 64'(cpu_stall), 64'd1);
            if (c == 5) begin
                check("conc_c5_stall", 64'(cpu_stall), 64'd0);
                check("conc_c5_states", {60'd0, dbg_inst_state, dbg_data_state}, {60'd0, HOLD, HOLD});
            end
            if (c == 6) check("conc_c6_states", {60'd0, dbg_inst_state, dbg_data_state}, {60'd0, IDLE, IDLE});
            step();
        end
        check("conc_stall_cycles", 64'(stall_cnt), 64'd5);
        check("conc_inst_rdata", 64'(cpu_inst_rdata), 64'h2402_0005);
        check("conc_data_rdata", 64'(cpu_data_rdata), 64'h1357_9BDF);
        idle_inputs();
        #1;

        // Reset while waiting in DATA, then a late data_ok.
        cpu_data_en   = 1'b1;
        cpu_data_addr = 32'h8000_0080;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        #1;
        check("rst_mid_in_data", 64'(dbg_data_state), 64'(DATA));
        rst         = 1'b1;
        cpu_data_en = 1'b0;
        step();
        rst          = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_DEAD;
        #1;
        check("rst_mid_req", 64'(data_req), 64'd0);
        check("rst_mid_state", 64'(dbg_data_state), 64'(IDLE));
        step();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        #1;
        check("rst_mid_late_ok_state", 64'(dbg_data_state), 64'(IDLE));
        check("rst_mid_rdata", 64'(cpu_data_rdata), 64'd0);
        check("rst_mid_req_after", 64'(data_req), 64'd0);
        check("rst_mid_stall", 64'(cpu_stall), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
